// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus bundle for the load/store unit.
// slave = the unit's view; master = the pipeline/memory side that drives it.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_error;
  logic [31:0]           mem_address;
  logic                  mem_read_en;
  logic                  mem_write_en;
  logic [31:0]           mem_data_out;
  logic [31:0]           mem_data_in;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_data_in,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_read_en, mem_write_en, mem_data_out
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_data_in,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_read_en, mem_write_en, mem_data_out
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit over a word-indexed memory, with read-modify-write
// for sub-word stores. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit #(
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  load_store_unit_if.slave       bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [1:0] LAST_CNT = 2'(READ_LATENCY - 1);

  state_t                state_q, state_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            cnt_q, cnt_d;

  logic                  accept;
  logic                  req_is_word;
  logic [3:0]            lane_mask;
  logic [31:0]           merged;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [31:0]           load_ext;

`ifdef LSU_MISALIGN_TRAP_EN
  logic                  err_q, err_d;
  logic                  misaligned;

  assign misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                      (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`endif

  assign accept      = bus.req_valid && (state_q == IDLE);
  assign req_is_word = bus.req_size[1];

  // Lane extraction for loads; misaligned low bits below the lane are ignored.
  assign byte_sel = bus.mem_data_in[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = bus.mem_data_in[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = bus.mem_data_in;
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_ext = bus.mem_data_in;
    endcase
  end

  always_comb begin
    lane_mask = 4'b1111;
    case (size_q)
      2'b00:   lane_mask = 4'b0001 << addr_q[1:0];
      2'b01:   lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  // Half stores feed wdata[15:8] into odd lanes; byte stores replicate wdata[7:0].
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = lane_mask[gi]
                               ? ((size_q == 2'b00) ? wdata_q[7:0] : wdata_q[8*(gi%2) +: 8])
                               : bus.mem_data_in[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
`ifdef LSU_MISALIGN_TRAP_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d  = bus.req_write;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          rdata_d  = '0;
          cnt_d    = '0;
          state_d  = (bus.req_write && req_is_word) ? WR : RD;
`ifdef LSU_MISALIGN_TRAP_EN
          err_d    = misaligned;
          if (misaligned) state_d = RESP;
`endif
        end
      end
      RD: begin
        if (cnt_q == LAST_CNT) begin
          if (write_q) begin
            wdata_d = merged;
            state_d = WR;
          end else begin
            rdata_d = load_ext;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end
  assign bus.resp_error = (state_q == RESP) && err_q;
`else
  assign bus.resp_error = 1'b0;
`endif

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.mem_read_en  = (state_q == RD);
  assign bus.mem_write_en = (state_q == WR);
  assign bus.mem_data_out = (state_q == WR) ? wdata_q : 32'h0;
  assign bus.mem_address  = 32'(addr_q[ADDR_WIDTH-1:2]);
  assign bus.resp_valid   = (state_q == RESP);
  assign bus.resp_rdata   = rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
// Samples outputs 1 time unit after each rising edge.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  int wr_count = 0;

  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic [31:0] mem [0:15];

  load_store_unit_if #(.ADDR_WIDTH(32)) bus_if ();

  load_store_unit #(.ADDR_WIDTH(32), .READ_LATENCY(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  assign bus_if.mem_data_in = bus_if.mem_read_en ? mem[bus_if.mem_address[3:0]] : 32'h0;

  always @(posedge clk) begin
    if (bus_if.mem_write_en) begin
      mem[bus_if.mem_address[3:0]] <= bus_if.mem_data_out;
      wr_count <= wr_count + 1;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  // Returns sampled in cycle N+1 (just after the accept edge).
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    bus_if.req_valid = 1'b1; bus_if.req_write = w; bus_if.req_size = sz;
    bus_if.req_signed = sg; bus_if.req_addr = a; bus_if.req_wdata = wd;
    step();
    bus_if.req_valid = 1'b0;
    bus_if.req_wdata = 32'h5555_AAAA;
    bus_if.req_addr  = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset();
    vectors++;
    if (bus_if.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", bus_if.req_ready); end
    vectors++;
    if ({bus_if.mem_read_en, bus_if.mem_write_en, bus_if.resp_valid, bus_if.resp_error} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags got %b want 0000",
        {bus_if.mem_read_en, bus_if.mem_write_en, bus_if.resp_valid, bus_if.resp_error});
    end
    vectors++;
    if ({bus_if.mem_address, bus_if.mem_data_out, bus_if.resp_rdata} !== 96'h0) begin
      miscompares++; $display("FAIL reset_data got %h %h %h want 0", bus_if.mem_address, bus_if.mem_data_out, bus_if.resp_rdata);
    end
    $display("txn reset: outputs checked");
  endtask

  task automatic test_load_word();
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    vectors++;
    if (bus_if.mem_read_en !== 1'b1 || bus_if.mem_address !== 32'd1 || bus_if.resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL ldw_rd got rd=%b addr=%h rv=%b want rd=1 addr=1 rv=0",
        bus_if.mem_read_en, bus_if.mem_address, bus_if.resp_valid);
    end
    step();
    vectors++;
    if (bus_if.resp_valid !== 1'b1 || bus_if.resp_rdata !== 32'hDEADBEEF || bus_if.mem_read_en !== 1'b0) begin
      miscompares++; $display("FAIL ldw_resp got rv=%b data=%h rd=%b want rv=1 data=deadbeef rd=0",
        bus_if.resp_valid, bus_if.resp_rdata, bus_if.mem_read_en);
    end
    step();
    vectors++;
    if (bus_if.resp_valid !== 1'b0 || bus_if.req_ready !== 1'b1) begin
      miscompares++; $display("FAIL ldw_idle got rv=%b ready=%b want rv=0 ready=1", bus_if.resp_valid, bus_if.req_ready);
    end
    $display("txn load word @0x4 -> %h", bus_if.resp_rdata);
  endtask

  task automatic test_load_subword();
    logic [1:0]  sz  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        sg  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad  [4] = '{32'h7, 32'h7, 32'h4, 32'h6};
    logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, sz[i], sg[i], ad[i], 32'h0);
      step();
      vectors++;
      if (bus_if.resp_valid !== 1'b1 || bus_if.resp_rdata !== exp[i]) begin
        miscompares++; $display("FAIL ld_sub%0d got rv=%b data=%h want rv=1 data=%h",
          i, bus_if.resp_valid, bus_if.resp_rdata, exp[i]);
      end
      $display("txn load size=%0d signed=%0d @%h -> %h", sz[i], sg[i], ad[i], bus_if.resp_rdata);
      step();
    end
  endtask

  task automatic test_store_half();
    issue(1'b1, 2'b01, 1'b0, 32'h6, 32'hFFFF1234);
    vectors++;
    if (bus_if.mem_read_en !== 1'b1 || bus_if.mem_write_en !== 1'b0) begin
      miscompares++; $display("FAIL sth_rd got rd=%b wr=%b want rd=1 wr=0", bus_if.mem_read_en, bus_if.mem_write_en);
    end
    step();
    vectors++;
    if (bus_if.mem_write_en !== 1'b1 || bus_if.mem_read_en !== 1'b0 || bus_if.mem_data_out !== 32'h1234BEEF ||
        bus_if.mem_address !== 32'd1) begin
      miscompares++; $display("FAIL sth_wr got wr=%b rd=%b data=%h addr=%h want wr=1 rd=0 data=1234beef addr=1",
        bus_if.mem_write_en, bus_if.mem_read_en, bus_if.mem_data_out, bus_if.mem_address);
    end
    step();
    vectors++;
    if (bus_if.resp_valid !== 1'b1 || bus_if.resp_rdata !== 32'h0 || bus_if.mem_write_en !== 1'b0) begin
      miscompares++; $display("FAIL sth_resp got rv=%b data=%h wr=%b want rv=1 data=0 wr=0",
        bus_if.resp_valid, bus_if.resp_rdata, bus_if.mem_write_en);
    end
    vectors++;
    if (mem[1] !== 32'h1234BEEF) begin miscompares++; $display("FAIL sth_mem got %h want 1234beef", mem[1]); end
    $display("txn store half 1234 @0x6 -> mem[1]=%h", mem[1]);
    step();
    preload(4'd1, 32'hDEADBEEF);
    issue(1'b1, 2'b00, 1'b0, 32'h5, 32'h000000AB);
    step();
    vectors++;
    if (bus_if.mem_data_out !== 32'hDEADABEF) begin
      miscompares++; $display("FAIL stb_data got %h want deadabef", bus_if.mem_data_out);
    end
    step();
    step();
    $display("txn store byte ab @0x5 -> mem[1]=%h", mem[1]);
    preload(4'd1, 32'hDEADBEEF);
  endtask

  task automatic test_store_word();
    issue(1'b1, 2'b10, 1'b0, 32'h8, 32'h00C0FFEE);
    vectors++;
    if (bus_if.mem_write_en !== 1'b1 || bus_if.mem_read_en !== 1'b0 || bus_if.mem_address !== 32'd2 ||
        bus_if.mem_data_out !== 32'h00C0FFEE || bus_if.req_ready !== 1'b0) begin
      miscompares++; $display("FAIL stw_wr got wr=%b rd=%b addr=%h data=%h ready=%b want 1 0 2 00c0ffee 0",
        bus_if.mem_write_en, bus_if.mem_read_en, bus_if.mem_address, bus_if.mem_data_out, bus_if.req_ready);
    end
    step();
    vectors++;
    if (bus_if.resp_valid !== 1'b1 || bus_if.mem_write_en !== 1'b0 || bus_if.mem_read_en !== 1'b0 ||
        bus_if.req_ready !== 1'b0 || bus_if.mem_data_out !== 32'h0) begin
      miscompares++; $display("FAIL stw_resp got rv=%b wr=%b rd=%b ready=%b dout=%h want 1 0 0 0 0",
        bus_if.resp_valid, bus_if.mem_write_en, bus_if.mem_read_en, bus_if.req_ready, bus_if.mem_data_out);
    end
    step();
    vectors++;
    if (bus_if.req_ready !== 1'b1 || mem[2] !== 32'h00C0FFEE) begin
      miscompares++; $display("FAIL stw_done got ready=%b mem2=%h want ready=1 mem2=00c0ffee", bus_if.req_ready, mem[2]);
    end
    $display("txn store word 00c0ffee @0x8 -> mem[2]=%h", mem[2]);
  endtask

  task automatic test_reset_abort();
    int wr_before;
    wr_before = wr_count;
    issue(1'b1, 2'b00, 1'b0, 32'hC, 32'h00000077);
    vectors++;
    if (bus_if.mem_read_en !== 1'b1) begin miscompares++; $display("FAIL abort_rd got %b want 1", bus_if.mem_read_en); end
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus_if.mem_read_en, bus_if.mem_write_en, bus_if.resp_valid} !== 3'b000 || bus_if.mem_address !== 32'h0) begin
      miscompares++; $display("FAIL abort_drop got rd/wr/rv=%b addr=%h want 000 addr=0",
        {bus_if.mem_read_en, bus_if.mem_write_en, bus_if.resp_valid}, bus_if.mem_address);
    end
    step();
    step();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (bus_if.resp_valid !== 1'b0 || bus_if.mem_write_en !== 1'b0 || bus_if.req_ready !== 1'b1) begin
        miscompares++; $display("FAIL abort_after%0d got rv=%b wr=%b ready=%b want 0 0 1",
          i, bus_if.resp_valid, bus_if.mem_write_en, bus_if.req_ready);
      end
    end
    vectors++;
    if (mem[3] !== 32'h11223344 || wr_count !== wr_before) begin
      miscompares++; $display("FAIL abort_mem got mem3=%h writes=%0d want 11223344 writes=%0d", mem[3], wr_count, wr_before);
    end
    $display("txn byte store aborted by reset -> mem[3]=%h", mem[3]);
  endtask

  task automatic test_misalign();
    issue(1'b0, 2'b10, 1'b0, 32'h5, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    vectors++;
    if (bus_if.resp_valid !== 1'b1 || bus_if.resp_error !== 1'b1 || bus_if.resp_rdata !== 32'h0 ||
        bus_if.mem_read_en !== 1'b0 || bus_if.mem_write_en !== 1'b0) begin
      miscompares++; $display("FAIL mis_trap got rv=%b err=%b data=%h rd=%b wr=%b want 1 1 0 0 0",
        bus_if.resp_valid, bus_if.resp_error, bus_if.resp_rdata, bus_if.mem_read_en, bus_if.mem_write_en);
    end
    step();
`else
    vectors++;
    if (bus_if.mem_read_en !== 1'b1 || bus_if.mem_address !== 32'd1) begin
      miscompares++; $display("FAIL mis_rd got rd=%b addr=%h want rd=1 addr=1", bus_if.mem_read_en, bus_if.mem_address);
    end
    step();
    vectors++;
    if (bus_if.resp_valid !== 1'b1 || bus_if.resp_rdata !== 32'hDEADBEEF || bus_if.resp_error !== 1'b0) begin
      miscompares++; $display("FAIL mis_resp got rv=%b data=%h err=%b want 1 deadbeef 0",
        bus_if.resp_valid, bus_if.resp_rdata, bus_if.resp_error);
    end
    step();
`endif
    vectors++;
    if (bus_if.req_ready !== 1'b1 || bus_if.resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL mis_idle got ready=%b rv=%b want 1 0", bus_if.req_ready, bus_if.resp_valid);
    end
    $display("txn load word @0x5 (misaligned) completed");
  endtask

  initial begin
    bus_if.req_valid = 1'b0; bus_if.req_write = 1'b0; bus_if.req_size = 2'b00;
    bus_if.req_signed = 1'b0; bus_if.req_addr = '0; bus_if.req_wdata = '0;
    #2 reset_n = 1'b0;
    #20;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    preload(4'd0, 32'h0);
    preload(4'd1, 32'hDEADBEEF);
    preload(4'd2, 32'h0);
    preload(4'd3, 32'h11223344);
    test_load_word();
    test_load_subword();
    test_store_half();
    test_store_word();
    test_reset_abort();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got no completion want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access initiator between the CPU execute stage and the word-indexed data memory (clk, address, write_en, read_en, data_in, data_out).
- Accepts byte, halfword and word load/store requests from the pipeline through a valid/ready handshake.
- Translates each request into word-granular memory reads and writes, using read-modify-write for sub-word stores.
- Returns load data, sign- or zero-extended, with a single-cycle response pulse.

Parameters:
ADDR_WIDTH, 32, width of the byte address from the pipeline; mem_address = req_addr[ADDR_WIDTH-1:2], zero-extended to 32 bits.
READ_LATENCY, 1, cycles mem_read_en is held before mem_data_in is sampled; legal range 1..4.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  unit idle and able to accept.
req_write  input  1  1 = store, 0 = load.
req_size  input  2  00 byte, 01 half, 10 word; 11 is treated as word.
req_signed  input  1  sign-extend load data (ignored for stores and word loads).
req_addr  input  ADDR_WIDTH  byte address.
req_wdata  input  32  store data, right-justified.
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  32  extended load data; 0 for stores.
resp_error  output  1  misaligned access (see Optional Feature); constant 0 when the feature is compiled out.
mem_address  output  32  word index to data memory.
mem_read_en  output  1  memory read enable.
mem_write_en  output  1  memory write enable.
mem_data_out  output  32  write data to memory; 0 whenever mem_write_en is 0.
mem_data_in  input  32  read data from memory.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE and any in-flight operation aborts with no response.
  - mem_read_en, mem_write_en, resp_valid and resp_error clear immediately.
  - mem_address, mem_data_out and resp_rdata go to 0.
  - req_ready is 1 once in IDLE.
- State machine: IDLE, RD, WR, RESP. req_ready = (state == IDLE). Capture all req_* fields on the accept edge (req_valid & req_ready); later input changes are ignored.
- IDLE -> RD on load or sub-word store; IDLE -> WR on word store.
- RD:
  - mem_read_en = 1 and mem_address is held for READ_LATENCY cycles.
  - mem_data_in is sampled on the final RD edge.
  - Go to RESP for a load, or WR for a sub-word store.
- WR:
  - Exactly one cycle with mem_write_en = 1.
  - mem_data_out = req_wdata for a word store.
  - For a sub-word store, mem_data_out = the read word with the target lane replaced. Byte lane k = bits [8k+7:8k], k = addr[1:0], little-endian. Half lane = addr[1], bits [16h+15:16h].
  - Go to RESP.
- RESP:
  - One cycle with resp_valid = 1, then IDLE.
  - resp_rdata = selected lane, sign-extended if req_signed, else zero-extended.
- Latency (accept edge = cycle N, L = READ_LATENCY):
  - word store: resp_valid in cycle N+2
  - load: resp_valid in cycle N+L+1
  - sub-word store: resp_valid in cycle N+L+2
- mem_read_en and mem_write_en are never high together.
- There is no response backpressure, and no new request is accepted until back in IDLE.

Optional Feature:
Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned accesses are a half with addr[0] = 1, or a word with addr[1:0] != 0.
  - A misaligned access issues no memory enables and goes directly IDLE -> RESP.
  - In RESP, resp_valid = 1, resp_error = 1 and resp_rdata = 0.
- Undefined:
  - resp_error is tied to 0.
  - Misaligned low address bits are ignored: a half uses addr[1] only, and a word uses the aligned word.

Test Plan:
1. Memory word 1 = 0xDEADBEEF, L = 1; load word at addr 0x4 -> mem_read_en = 1 and mem_address = 1 in cycle N+1; resp_valid = 1 with resp_rdata = 0xDEADBEEF in N+2.
2. Load byte at addr 0x7 with req_signed = 1 -> resp_rdata = 0xFFFFFFDE; same load with req_signed = 0 -> 0x000000DE.
3. Store half 0x1234 at addr 0x6 with word 1 = 0xDEADBEEF -> read in N+1, mem_write_en = 1 with mem_data_out = 0x1234BEEF in N+2, resp_valid in N+3, resp_rdata = 0.
4. Store word 0x00C0FFEE at addr 0x8 -> mem_read_en never asserted; mem_write_en = 1 with mem_address = 2 in N+1 only; resp_valid in N+2; req_ready = 0 from N+1 until return to IDLE.
5. Start a byte store, then drive reset_n low during RD -> enables drop at once, no write and no resp_valid; req_ready = 1 after release; memory unchanged.
6. Load word at addr 0x5 -> without the macro: returns word 1 with resp_error = 0; with LSU_MISALIGN_TRAP_EN: resp_valid = 1 and resp_error = 1 in N+1, no mem enables.
